// File: rtl/stage_fetch.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous imem, and feeds the IF-ID register.
// Latency: fetch issued at edge t is presented in IF-ID from t+1; a redirect costs one invalid entry.
// Stall freezes PC and IF-ID and parks the imem word in a hold buffer; FETCH_PERF_CNT_EN adds a bubble counter.
package stage_fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus_four;
        logic        valid;
    } if_id_reg_t;
endpackage

module stage_fetch
    import stage_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        jal_i,
    input  logic [31:0] jal_addr_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        imem_rd_en_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output if_id_reg_t  if_id_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt_o
`endif
);

    logic [31:0] pc_q;
    logic [31:0] out_pc_q;
    logic [31:0] out_pc4_q;
    logic        out_valid_q;
    logic [31:0] hold_q;
    logic        hold_valid_q;

    logic [31:0] pc_plus_four;
    logic [31:0] redirect_tgt;
    logic [31:0] branch_tgt;

    // Branch is older than the JAL in decode, so it wins; targets are word-aligned by truncation.
    assign redirect_tgt = (branch_i ? branch_addr_i : jal_addr_i) & ~32'd3;
    assign branch_tgt   = branch_addr_i & ~32'd3;
    assign pc_plus_four = pc_q + 32'd4;

    assign imem_addr_o  = pc_q;
    assign imem_rd_en_o = rst_ni & ~stall_i;
    assign instr_o      = hold_valid_q ? hold_q : imem_rdata_i;

    assign if_id_o.pc           = out_pc_q;
    assign if_id_o.pc_plus_four = out_pc4_q;
    assign if_id_o.valid        = out_valid_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q         <= RESET_PC;
            out_pc_q     <= 32'd0;
            out_pc4_q    <= 32'd0;
            out_valid_q  <= 1'b0;
            hold_q       <= 32'd0;
            hold_valid_q <= 1'b0;
        end else if (stall_i) begin
            // The imem output is only valid for one cycle, so capture it on the first stalled edge.
            if (!hold_valid_q) begin
                hold_q       <= imem_rdata_i;
                hold_valid_q <= 1'b1;
            end
            // A JAL is re-presented by decode after the stall; a branch is not, so take it now.
            if (branch_i) begin
                pc_q        <= branch_tgt;
                out_valid_q <= 1'b0;
            end
        end else begin
            out_pc_q     <= pc_q;
            out_pc4_q    <= pc_plus_four;
            out_valid_q  <= ~(branch_i | jal_i);
            pc_q         <= (branch_i | jal_i) ? redirect_tgt : pc_plus_four;
            hold_valid_q <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            bubble_cnt_q <= 32'd0;
        end else if (!stall_i && !out_valid_q) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Randomized bench for stage_fetch: compares against a fetch-sequence reference model and an imem content function.
module tb_stage_fetch;
    import stage_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_ni;
    logic        stall_i;
    logic        jal_i;
    logic [31:0] jal_addr_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        imem_rd_en_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    if_id_reg_t  if_id_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt_o;
`endif

    stage_fetch #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .stall_i      (stall_i),
        .jal_i        (jal_i),
        .jal_addr_i   (jal_addr_i),
        .branch_i     (branch_i),
        .branch_addr_i(branch_addr_i),
        .imem_rd_en_o (imem_rd_en_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .instr_o      (instr_o),
        .if_id_o      (if_id_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0108) return 32'h00A0_0093;
        return {a[15:0] ^ 16'h5A3C, ~a[31:16]} + 32'h0000_0013;
    endfunction

    // Synchronous imem; an idle cycle leaves garbage on the read port.
    always @(posedge clk) begin
        if (imem_rd_en_o) imem_rdata_i <= mem_word(imem_addr_o);
        else              imem_rdata_i <= $urandom;
    end

    // Reference: next fetch address, the entry decode currently sees, bubbles delivered.
    logic [31:0] m_pc;
    logic [31:0] m_ent_pc;
    logic [31:0] m_ent_pc4;
    logic        m_ent_valid;
    logic [31:0] m_bub;
    logic        in_run;
    logic [31:0] run_instr;

    task automatic model_reset();
        m_pc = RST_PC; m_ent_pc = 0; m_ent_pc4 = 0; m_ent_valid = 0; m_bub = 0; in_run = 0;
    endtask

    task automatic check_regs();
        check("ifid_pc", if_id_o.pc, m_ent_pc);
        check("ifid_pc4", if_id_o.pc_plus_four, m_ent_pc4);
        check("ifid_valid", if_id_o.valid, m_ent_valid);
        if (m_ent_valid) check("instr", instr_o, mem_word(m_ent_pc));
`ifdef FETCH_PERF_CNT_EN
        check("bubble_cnt", bubble_cnt_o, m_bub);
`endif
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input logic s, input logic j, input logic [31:0] ja,
                        input logic b, input logic [31:0] ba);
        stall_i = s; jal_i = j; jal_addr_i = ja; branch_i = b; branch_addr_i = ba;
        #1;
        check("rd_en", imem_rd_en_o, !s);
        check("imem_addr", imem_addr_o, m_pc);
        if (s && !in_run) begin
            in_run = 1; run_instr = instr_o;
        end else if (in_run) begin
            check("instr_hold", instr_o, run_instr);
            if (!s) in_run = 0;
        end
        if (!s) begin
            if (!m_ent_valid) m_bub = m_bub + 1;
            m_ent_pc = m_pc; m_ent_pc4 = m_pc + 4; m_ent_valid = !(b || j);
            if (b)      m_pc = {ba[31:2], 2'b00};
            else if (j) m_pc = {ja[31:2], 2'b00};
            else        m_pc = m_pc + 4;
        end else if (b) begin
            m_pc = {ba[31:2], 2'b00}; m_ent_valid = 0;
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic adv();
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_ni = 0; stall_i = 0; jal_i = 0; branch_i = 0; jal_addr_i = 0; branch_addr_i = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rd_en", imem_rd_en_o, 0);
        check("rst_addr", imem_addr_o, RST_PC);
        check_regs();
        rst_ni = 1;

        // Sequential fetch from RESET_PC.
        adv();
        check("seq_first_pc", if_id_o.pc, 32'h100);
        check("seq_first_pc4", if_id_o.pc_plus_four, 32'h104);
        adv(); adv();
        check("seq_at_108", if_id_o.pc, 32'h108);

        // Three-cycle stall with garbage on the read port, then release.
        repeat (3) step(1, 0, 0, 0, 0);
        check("stall_instr", instr_o, 32'h00A0_0093);
        adv();
        check("after_stall_pc", if_id_o.pc, 32'h10C);

        // JAL: one invalid entry, then the target.
        step(0, 1, 32'h200, 0, 0);
        check("jal_bubble", if_id_o.valid, 0);
        adv();
        check("jal_target", if_id_o.pc, 32'h200);
        check("jal_target_pc4", if_id_o.pc_plus_four, 32'h204);

        // Branch beats JAL in the same cycle.
        step(0, 1, 32'h200, 1, 32'h300);
        adv();
        check("prio_target", if_id_o.pc, 32'h300);

        // Branch on the second stall cycle; JAL during stall ignored.
        step(1, 0, 0, 0, 0);
        step(1, 1, 32'h200, 1, 32'h400);
        check("stall_branch_kill", if_id_o.valid, 0);
        step(1, 1, 32'h500, 0, 0);
        step(0, 0, 0, 0, 0);
        check("stall_branch_target", if_id_o.pc, 32'h400);

        // Unaligned target truncation and PC wrap at 2^32.
        step(0, 0, 0, 1, 32'hFFFF_FFFE);
        adv();
        check("wrap_pc4", if_id_o.pc_plus_four, 32'h0);
        adv();
        check("wrap_pc", if_id_o.pc, 32'h0);

        // Asynchronous reset in the middle of a stall with the hold buffer loaded.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        #2 rst_ni = 0;
        #1;
        model_reset();
        check("arst_valid", if_id_o.valid, 0);
        check("arst_pc", if_id_o.pc, 0);
        check("arst_addr", imem_addr_o, RST_PC);
        check("arst_rd_en", imem_rd_en_o, 0);
        check("arst_instr", instr_o, imem_rdata_i);
`ifdef FETCH_PERF_CNT_EN
        check("arst_bubble", bubble_cnt_o, 0);
`endif
        @(negedge clk);
        rst_ni = 1;
        adv();
        check("arst_restart", if_id_o.pc, RST_PC);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic        s, j, b;
            logic [31:0] ja, ba;
            s  = ($urandom_range(99) < 30);
            j  = ($urandom_range(99) < 15);
            b  = ($urandom_range(99) < 10);
            ja = $urandom;
            ba = ($urandom_range(19) == 0) ? 32'hFFFF_FFFD : $urandom;
            step(s, j, ja, b, ba);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
